// File: rtl/neuron_accumulator.sv
// Accumulates a stream of signed 32-bit weighted products into a wide sum.
// Adds the bias, saturates to 32 bits, optionally applies ReLU, and presents one activation per stream.
module neuron_accumulator #(
    parameter int ACC_WIDTH = 40,
    parameter int MAX_TERMS = 256,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] prod_in,
    input  logic        prod_valid,
    input  logic        prod_last,
    output logic        prod_ready,
    input  logic [31:0] bias,
    output logic [31:0] neuron_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat_flag,
    output logic        trunc_flag
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
    localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-32){1'b1}}, 32'h8000_0000};

    typedef enum logic [1:0] {ACCUM, FINISH, OUTPUT} state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [31:0]                   neuron_out_q, neuron_out_d;
    logic                          out_valid_q, out_valid_d;
    logic                          sat_q, sat_d;
    logic                          trunc_q, trunc_d;
    logic                          rdy_en_q;
    logic signed [SUM_W-1:0]       sum;
    logic [31:0]                   sat_val;

    function automatic logic is_sat(input logic signed [SUM_W-1:0] s);
        return (s > SAT_HI) || (s < SAT_LO);
    endfunction

    function automatic logic [31:0] saturate(input logic signed [SUM_W-1:0] s);
        if (s > SAT_HI)
            return 32'h7FFF_FFFF;
        else if (s < SAT_LO)
            return 32'h8000_0000;
        else
            return s[31:0];
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] v);
        return (RELU_EN && v[31]) ? 32'h0 : v;
    endfunction

    // The extra sum bit keeps acc + bias exact even at the accumulator extremes.
    assign sum = {acc_q[ACC_WIDTH-1], acc_q} + {{(SUM_W-32){bias[31]}}, bias};
    assign sat_val = saturate(sum);

    assign prod_ready = (state_q == ACCUM) && rdy_en_q;
    assign neuron_out = neuron_out_q;
    assign out_valid  = out_valid_q;
    assign sat_flag   = sat_q;
    assign trunc_flag = trunc_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        neuron_out_d = neuron_out_q;
        out_valid_d  = out_valid_q;
        sat_d        = sat_q;
        trunc_d      = trunc_q;
        case (state_q)
            ACCUM: begin
                if (prod_valid && prod_ready) begin
                    acc_d   = acc_q + {{(ACC_WIDTH-32){prod_in[31]}}, prod_in};
                    count_d = count_q + CNT_W'(1);
                    if (prod_last) begin
                        state_d = FINISH;
                    end else if (count_q + CNT_W'(1) == CNT_MAX) begin
                        trunc_d = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                // sat_flag reports saturation before ReLU is applied.
                sat_d        = is_sat(sum);
                neuron_out_d = relu(sat_val);
                out_valid_d  = 1'b1;
                state_d      = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    trunc_d     = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            count_q      <= '0;
            neuron_out_q <= '0;
            out_valid_q  <= 1'b0;
            sat_q        <= 1'b0;
            trunc_q      <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            neuron_out_q <= neuron_out_d;
            out_valid_q  <= out_valid_d;
            sat_q        <= sat_d;
            trunc_q      <= trunc_d;
            rdy_en_q     <= 1'b1;
        end
    end

endmodule
